axi_lite_master_bridge: RTL

Synthesizable AXI4-Lite initiator that turns a simple valid/ready command stream into single AXI4-Lite read or write transactions. It is the master-side counterpart of `axi_lite_reg_interface`. Used by on-chip sequencers, and by the DMA self-test path, to program and poll DMA registers without a CPU. Exactly one transaction is outstanding at a time; each response is returned on a valid/ready response port.

---
 rtl/axi_lite_master_bridge.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master_bridge.sv
// AXI4-Lite initiator: turns a valid/ready command stream into single AXI4-Lite
// read/write transactions, one outstanding at a time, with a registered response port.
module axi_lite_master_bridge #(
  parameter int ADDR_WIDTH    = 32,
  parameter int REG_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  // command stream
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [REG_WIDTH-1:0]       cmd_wdata,
  input  logic [REG_WIDTH/8-1:0]     cmd_wstrb,
  // response stream
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_write,
  output logic [REG_WIDTH-1:0]       rsp_rdata,
  output logic [1:0]                 rsp_resp,
  output logic                       busy,
  output logic [ERR_CNT_WIDTH-1:0]   err_count,
  // AXI4-Lite master
  output logic [ADDR_WIDTH-1:0]      AWADDR,
  output logic                       AWVALID,
  input  logic                       AWREADY,
  output logic [REG_WIDTH-1:0]       WDATA,
  output logic [REG_WIDTH/8-1:0]     WSTRB,
  output logic                       WVALID,
  input  logic                       WREADY,
  input  logic                       BVALID,
  output logic                       BREADY,
  input  logic [1:0]                 BRESP,
  output logic [ADDR_WIDTH-1:0]      ARADDR,
  output logic                       ARVALID,
  input  logic                       ARREADY,
  input  logic [REG_WIDTH-1:0]       RDATA,
  input  logic                       RVALID,
  output logic                       RREADY,
  input  logic [1:0]                 RRESP
);

  localparam int STRB_WIDTH = REG_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t                   state_q;
  logic                     cmd_ready_q, busy_q, rsp_valid_q, rsp_write_q;
  logic                     awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                     aw_done_q, w_done_q;
  logic [ADDR_WIDTH-1:0]    awaddr_q, araddr_q;
  logic [REG_WIDTH-1:0]     wdata_q, rsp_rdata_q;
  logic [STRB_WIDTH-1:0]    wstrb_q;
  logic [1:0]               rsp_resp_q;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic       aw_hs, w_hs, aw_fin, w_fin;
  logic [1:0] resp_in;

  assign aw_hs  = awvalid_q & AWREADY;
  assign w_hs   = wvalid_q & WREADY;
  assign aw_fin = aw_done_q | aw_hs;
  assign w_fin  = w_done_q | w_hs;

  // Only one of B/R can be captured at a time, so a single saturating
  // increment serves both response channels.
  assign resp_in = (state_q == WR_B) ? BRESP : RRESP;

  always_comb begin
    err_count_d = err_count_q;
    if ((resp_in != 2'b00) && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
      err_count_q <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rsp_write_q <= cmd_write;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= WR_AW_W;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          // AW and W retire independently; B is only opened once both are done.
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= WR_B;
          end
        end
        WR_B: begin
          if (BVALID) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= BRESP;
            rsp_rdata_q <= '0;
            err_count_q <= err_count_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RD_AR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (RVALID) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= RRESP;
            rsp_rdata_q <= RDATA;
            err_count_q <= err_count_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_count_q;
  assign AWADDR    = awaddr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = araddr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule
